// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by both masters, the memory slave port and the error flag.
// The arbiter uses modport slave; the surrounding system uses modport master.
interface mem_arbiter_if;
   logic [31:0] m0_addr;
   logic [3:0]  m0_oe;
   logic [31:0] m0_wdata;
   logic [3:0]  m0_we;
   logic [31:0] m0_rdata;
   logic        m0_valid;
   logic        m0_ready;

   logic        m1_req;
   logic [31:0] m1_addr;
   logic [3:0]  m1_oe;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_we;
   logic        m1_gnt;
   logic [31:0] m1_rdata;
   logic        m1_valid;

   logic [31:0] s_addr;
   logic [3:0]  s_oe;
   logic [31:0] s_wdata;
   logic [3:0]  s_we;
   logic [31:0] s_rdata;
   logic        s_valid;

   logic        err;

   modport slave (
      input  m0_addr, m0_oe, m0_wdata, m0_we,
      input  m1_req, m1_addr, m1_oe, m1_wdata, m1_we,
      input  s_rdata, s_valid,
      output m0_rdata, m0_valid, m0_ready,
      output m1_gnt, m1_rdata, m1_valid,
      output s_addr, s_oe, s_wdata, s_we,
      output err
   );

   modport master (
      output m0_addr, m0_oe, m0_wdata, m0_we,
      output m1_req, m1_addr, m1_oe, m1_wdata, m1_we,
      output s_rdata, s_valid,
      input  m0_rdata, m0_valid, m0_ready,
      input  m1_gnt, m1_rdata, m1_valid,
      input  s_addr, s_oe, s_wdata, s_we,
      input  err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one data-memory port, with an in-order read-ID FIFO for return routing.
// Define MEMARB_STARVE_GUARD_EN to add the m1 starvation guard (wait counter + forced m0 stall slot).
module mem_arbiter #(
   parameter int DEPTH  = 4,
   parameter int STARVE = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic             m0_access, m0_read, m1_access, m1_read;
   logic             m0_acc, m0_drop, m1_gnt_c;
   logic             push, push_id, pop, stray, head, force_slot;
   logic [DEPTH-1:0] id_mem;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt, cnt_next;
   logic             m0_ready_q, err_q;
   logic [31:0]      s_addr_q, s_wdata_q;
   logic [3:0]       s_oe_q, s_we_q;

   assign m0_access = (|bus.m0_oe) || (|bus.m0_we);
   assign m0_read   = bus.m0_oe[0] && !bus.m0_we[0];
   assign m1_access = (|bus.m1_oe) || (|bus.m1_we);
   assign m1_read   = bus.m1_oe[0] && !bus.m1_we[0];

   // m0 has already been promised a slot by m0_ready, so it always wins; m1 writes skip the FIFO check.
   assign m0_acc   = m0_access && m0_ready_q;
   assign m0_drop  = m0_access && !m0_ready_q;
   assign m1_gnt_c = bus.m1_req && !m0_acc && ((cnt < FULL) || !m1_read);

   assign push    = (m0_acc && m0_read) || (m1_gnt_c && m1_read && m1_access);
   assign push_id = !m0_acc;
   assign pop     = bus.s_valid && (cnt != '0);
   assign stray   = bus.s_valid && (cnt == '0);
   assign head    = id_mem[rd_ptr];

   assign bus.m0_valid = pop && !head;
   assign bus.m1_valid = pop && head;
   assign bus.m0_rdata = bus.s_rdata;
   assign bus.m1_rdata = bus.s_rdata;
   assign bus.m1_gnt   = m1_gnt_c;
   assign bus.m0_ready = m0_ready_q;
   assign bus.err      = err_q;
   assign bus.s_addr   = s_addr_q;
   assign bus.s_oe     = s_oe_q;
   assign bus.s_wdata  = s_wdata_q;
   assign bus.s_we     = s_we_q;

`ifdef MEMARB_STARVE_GUARD_EN
   localparam int WW = (STARVE > 2) ? $clog2(STARVE) : 1;
   localparam logic [WW-1:0] WMAX   = WW'(STARVE - 1);
   localparam logic [WW-1:0] W_ONE  = WW'(1);

   logic [WW-1:0] wait_cnt;

   // Saturates at STARVE-1 so the stall slot repeats until a full FIFO drains enough for m1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (!bus.m1_req || m1_gnt_c)
         wait_cnt <= '0;
      else if (wait_cnt != WMAX)
         wait_cnt <= wait_cnt + W_ONE;
   end

   assign force_slot = (wait_cnt == WMAX) && bus.m1_req && !m1_gnt_c;
`else
   assign force_slot = 1'b0;
`endif

   always_comb begin
      cnt_next = cnt;
      if (push && !pop)
         cnt_next = cnt + CNT_ONE;
      else if (!push && pop)
         cnt_next = cnt - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_mem <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= push_id;
            wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_ONE;
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_ONE;
         cnt <= cnt_next;
      end
   end

   // Ready is based on the post-update count, so an m0 read next cycle always has room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_ready_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         m0_ready_q <= (cnt_next < FULL) && !force_slot;
         err_q      <= err_q || m0_drop || stray;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_oe_q    <= '0;
         s_we_q    <= '0;
      end else if (m0_acc) begin
         s_addr_q  <= bus.m0_addr;
         s_wdata_q <= bus.m0_wdata;
         s_oe_q    <= bus.m0_oe;
         s_we_q    <= bus.m0_we;
      end else if (m1_gnt_c) begin
         s_addr_q  <= bus.m1_addr;
         s_wdata_q <= bus.m1_wdata;
         s_oe_q    <= bus.m1_oe;
         s_we_q    <= bus.m1_we;
      end else begin
         s_oe_q    <= '0;
         s_we_q    <= '0;
      end
   end

endmodule
